disp_slicer: RTL and testbench

Parametrised, registered word slicer between the value multiplexer and the board display and LED drivers. It captures a DATA_W-bit word through a valid/ready handshake and splits it into NSLICE = DATA_W/SLICE_W slices. One slice drives the display, either manually selected or auto-scrolled on a prescaled tick. A second, independently selected slice drives the LEDs.

---
 rtl/disp_slicer_pkg.sv | 22 ++
 rtl/disp_slicer_prescaler.sv | 41 ++++
 rtl/disp_slicer.sv | 159 +++++++++++++++
 tb/tb_disp_slicer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/disp_slicer_pkg.sv
// disp_slicer_pkg: shared types, default parameters and index clamp helper
// for the disp_slicer block and its prescaler.
package disp_slicer_pkg;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_SLICE_W    = 16;
  localparam int DEF_SCROLL_DIV = 50_000_000;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_MANUAL = 2'd1,
    ST_SCROLL = 2'd2
  } state_e;

  // Out-of-range indices (possible when NSLICE is not a power of two)
  // saturate to the most significant slice.
  function automatic int unsigned clamp_idx(input int unsigned idx,
                                            input int unsigned nslice);
    return (idx >= nslice) ? nslice - 1 : idx;
  endfunction

endpackage

// File: rtl/disp_slicer_prescaler.sv
// slice_prescaler: counts 0..SCROLL_DIV-1 while enabled and emits a
// one-cycle tick on the terminal count. Clear has priority over enable.
module slice_prescaler
  import disp_slicer_pkg::*;
#(
  parameter int SCROLL_DIV = DEF_SCROLL_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(SCROLL_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = en && !clr && (cnt_q == TERM);

  // Next count: clear, wrap at terminal count, or increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == TERM) ? '0 : cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/disp_slicer.sv
// disp_slicer: captures a word via valid/ready and drives one slice to the
// display (manual select or auto-scroll) and another slice to the LEDs.
// Build option: define SLICER_SCROLL_EN to compile in the auto-scroll
// prescaler and SCROLL state; otherwise mode is ignored.
module disp_slicer
  import disp_slicer_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int SLICE_W    = DEF_SLICE_W,
  parameter int SCROLL_DIV = DEF_SCROLL_DIV,
  parameter int IDX_W      = $clog2(DATA_W / SLICE_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              hold,
  input  logic              mode,
  input  logic [IDX_W-1:0]  sel,
  input  logic [IDX_W-1:0]  led_sel,
  output logic [SLICE_W-1:0] value_to_display,
  output logic [SLICE_W-1:0] value_to_LEDs,
  output logic [IDX_W-1:0]  disp_idx,
  output logic              disp_valid
);

  localparam int NSLICE = DATA_W / SLICE_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [IDX_W-1:0]    disp_idx_q, disp_idx_d;
  logic [SLICE_W-1:0]  disp_val_q, disp_val_d;
  logic [SLICE_W-1:0]  led_val_q, led_val_d;
  logic                disp_valid_q, disp_valid_d;
  logic                in_ready_q, in_ready_d;

  logic                capture;
  logic                scroll_mode;
  logic                tick;
  logic [IDX_W-1:0]    sel_c, led_sel_c;
  logic [SLICE_W-1:0]  slices [NSLICE];

  for (genvar gi = 0; gi < NSLICE; gi++) begin : g_slice
    assign slices[gi] = data_q[gi*SLICE_W +: SLICE_W];
  end

  // in_ready is registered, so hold takes effect one cycle later; the
  // registered in_ready doubles as the freeze qualifier so that a word the
  // source sees as accepted is never dropped or half-applied.
  assign capture   = in_valid && in_ready_q;
  assign sel_c     = IDX_W'(clamp_idx(32'(sel), NSLICE));
  assign led_sel_c = IDX_W'(clamp_idx(32'(led_sel), NSLICE));

`ifdef SLICER_SCROLL_EN
  logic pre_clr, pre_en;
  assign scroll_mode = mode;
  assign pre_clr     = (state_q != ST_SCROLL) || capture;
  assign pre_en      = (state_q == ST_SCROLL) && in_ready_q;

  slice_prescaler #(
    .SCROLL_DIV(SCROLL_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (pre_clr),
    .en   (pre_en),
    .tick (tick)
  );
`else
  localparam int unused_scroll_div = SCROLL_DIV;
  logic unused_mode;
  assign unused_mode = mode;
  assign scroll_mode = 1'b0;
  assign tick        = 1'b0;
`endif

  // FSM next state, stored word and display index selection.
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    disp_idx_d = disp_idx_q;
    if (capture) begin
      data_d = in_data;
    end
    case (state_q)
      ST_EMPTY: begin
        disp_idx_d = LAST_IDX;
        if (capture) begin
          state_d = scroll_mode ? ST_SCROLL : ST_MANUAL;
        end
      end
      ST_MANUAL: begin
        state_d = scroll_mode ? ST_SCROLL : ST_MANUAL;
        if (!scroll_mode) begin
          disp_idx_d = sel_c;
        end else if (capture) begin
          disp_idx_d = LAST_IDX;
        end
      end
      ST_SCROLL: begin
        state_d = scroll_mode ? ST_SCROLL : ST_MANUAL;
        if (!scroll_mode) begin
          disp_idx_d = sel_c;
        end else if (in_ready_q) begin
          if (capture) begin
            disp_idx_d = LAST_IDX;
          end else if (tick) begin
            disp_idx_d = (disp_idx_q == LAST_IDX) ? '0 : disp_idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
  end

  // Registered output values; blank until a word has been captured.
  always_comb begin
    in_ready_d   = ~hold;
    disp_valid_d = (state_q != ST_EMPTY);
    disp_val_d   = '0;
    led_val_d    = '0;
    if (state_q != ST_EMPTY) begin
      disp_val_d = slices[disp_idx_d];
      led_val_d  = slices[led_sel_c];
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_EMPTY;
      data_q       <= '0;
      disp_idx_q   <= LAST_IDX;
      disp_val_q   <= '0;
      led_val_q    <= '0;
      disp_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      disp_idx_q   <= disp_idx_d;
      disp_val_q   <= disp_val_d;
      led_val_q    <= led_val_d;
      disp_valid_q <= disp_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready         = in_ready_q;
  assign value_to_display = disp_val_q;
  assign value_to_LEDs    = led_val_q;
  assign disp_idx         = disp_idx_q;
  assign disp_valid       = disp_valid_q;

endmodule

// File: tb/tb_disp_slicer.sv
// tb_disp_slicer: directed and random stimulus for disp_slicer with a
// queue-based scoreboard fed by a cycle-level reference model.
module tb_disp_slicer;

  localparam int DATA_W = 32;
  localparam int SLICE_W = 8;
  localparam int DIV = 4;
  localparam int N = DATA_W / SLICE_W;
`ifdef SLICER_SCROLL_EN
  localparam bit SCROLL_EN = 1'b1;
`else
  localparam bit SCROLL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        hold;
  logic        mode;
  logic [1:0]  sel;
  logic [1:0]  led_sel;
  logic [7:0]  value_to_display;
  logic [7:0]  value_to_LEDs;
  logic [1:0]  disp_idx;
  logic        disp_valid;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  disp_slicer #(
    .DATA_W(DATA_W), .SLICE_W(SLICE_W), .SCROLL_DIV(DIV), .IDX_W(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .hold(hold), .mode(mode), .sel(sel),
    .led_sel(led_sel), .value_to_display(value_to_display),
    .value_to_LEDs(value_to_LEDs), .disp_idx(disp_idx), .disp_valid(disp_valid)
  );

  typedef struct packed {
    logic [7:0] disp;
    logic [7:0] led;
    logic [1:0] idx;
    logic       valid;
    logic       rdy;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state: the word as a whole, a flag for "have word",
  // whether the display is auto-scrolling, the scroll position and the
  // number of cycles spent at that position.
  bit          m_have, m_scroll, m_rdy;
  logic [31:0] m_word;
  int          m_idx, m_pre;

  function automatic logic [7:0] slice_of(input logic [31:0] w, input int k);
    return w[k*8 +: 8];
  endfunction

  function automatic int clampi(input int v);
    return (v > N - 1) ? N - 1 : v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_step();
    exp_t        e;
    bit          cap, mode_eff, have_old;
    logic [31:0] word_old;
    if (!rst_n) begin
      m_have = 0; m_scroll = 0; m_rdy = 0; m_word = '0;
      m_idx = N - 1; m_pre = 0;
      e = '{disp: 8'h00, led: 8'h00, idx: 2'd3, valid: 1'b0, rdy: 1'b0};
      exp_q.delete();
      exp_q.push_back(e);
    end else begin
      cap      = in_valid && m_rdy;
      mode_eff = SCROLL_EN ? mode : 1'b0;
      have_old = m_have;
      word_old = m_word;
      if (cap) $display("xfer data=%h mode=%0d", in_data, mode_eff);
      if (!m_have) begin
        if (cap) begin
          m_have = 1; m_scroll = mode_eff; m_pre = 0; m_word = in_data;
        end
      end else begin
        if (!mode_eff) begin
          m_idx = clampi(int'(sel)); m_pre = 0;
        end else if (!m_scroll) begin
          m_pre = 0;
          if (cap) m_idx = N - 1;
        end else if (m_rdy) begin
          if (cap) begin
            m_idx = N - 1; m_pre = 0;
          end else if (m_pre == DIV - 1) begin
            m_idx = (m_idx + 1) % N; m_pre = 0;
          end else begin
            m_pre++;
          end
        end
        m_scroll = mode_eff;
        if (cap) m_word = in_data;
      end
      e.disp  = have_old ? slice_of(word_old, m_idx) : 8'h00;
      e.led   = have_old ? slice_of(word_old, clampi(int'(led_sel))) : 8'h00;
      e.idx   = 2'(m_idx);
      e.valid = have_old;
      e.rdy   = ~hold;
      m_rdy   = ~hold;
      exp_q.push_back(e);
    end
  endtask

  // Model runs on every clock edge and on reset assertion.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      model_step();
    end
  end

  // Monitor: one scoreboard comparison per cycle, away from the clock edge.
  initial begin
    exp_t e, a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{disp: value_to_display, led: value_to_LEDs, idx: disp_idx,
              valid: disp_valid, rdy: in_ready};
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL scoreboard t=%0t disp=%h/%h led=%h/%h idx=%0d/%0d valid=%b/%b rdy=%b/%b (actual/required)",
                   $time, a.disp, e.disp, a.led, e.led, a.idx, e.idx, a.valid, e.valid, a.rdy, e.rdy);
        end
      end
    end
  end

  logic [7:0] seq_disp [5];
  logic [1:0] seq_idx  [5];

  initial begin
    hold = 0; mode = 0; sel = 0; led_sel = 0; in_valid = 0; in_data = '0;
    seq_disp = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h44};
    seq_idx  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_disp", 32'(value_to_display), 32'h0);
    chk("rst_led", 32'(value_to_LEDs), 32'h0);
    chk("rst_idx", 32'(disp_idx), 32'd3);
    chk("rst_valid", 32'(disp_valid), 32'd0);
    chk("rst_rdy", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rdy_after_rst", 32'(in_ready), 32'd1);

    // Manual capture
    sel = 2'd2; led_sel = 2'd0; in_valid = 1; in_data = 32'hA1B2C3D4;
    @(negedge clk); in_valid = 0;
    @(negedge clk);
    chk("man_disp", 32'(value_to_display), 32'hB2);
    chk("man_led", 32'(value_to_LEDs), 32'hD4);
    chk("man_valid", 32'(disp_valid), 32'd1);
    sel = 2'd3;
    @(negedge clk);
    chk("man_sel3", 32'(value_to_display), 32'hA1);

    // Hold blocks capture
    hold = 1;
    @(negedge clk);
    chk("hold_rdy", 32'(in_ready), 32'd0);
    in_valid = 1; in_data = 32'h55555555;
    repeat (10) begin
      @(negedge clk);
      chk("hold_disp", 32'(value_to_display), 32'hA1);
      chk("hold_idx", 32'(disp_idx), 32'd3);
      chk("hold_rdy", 32'(in_ready), 32'd0);
    end
    hold = 0;
    @(negedge clk);
    chk("release_rdy", 32'(in_ready), 32'd1);
    @(negedge clk); in_valid = 0;
    @(negedge clk);
    chk("release_disp", 32'(value_to_display), 32'h55);

`ifdef SLICER_SCROLL_EN
    // Auto-scroll from a fresh capture
    mode = 1;
    repeat (2) @(negedge clk);
    in_valid = 1; in_data = 32'h11223344;
    @(negedge clk); in_valid = 0;
    chk("scr_cap_idx", 32'(disp_idx), 32'd3);
    @(negedge clk);
    chk("scr_first", 32'(value_to_display), 32'h11);
    for (int k = 0; k < 5; k++) begin
      repeat ((k == 0) ? 3 : 4) @(negedge clk);
      chk("scr_step_disp", 32'(value_to_display), 32'(seq_disp[k]));
      chk("scr_step_idx", 32'(disp_idx), 32'(seq_idx[k]));
    end
    // Capture on the wrap cycle
    repeat (3) @(negedge clk);
    in_valid = 1; in_data = 32'hDEADBEEF;
    @(negedge clk); in_valid = 0;
    chk("cvt_idx", 32'(disp_idx), 32'd3);
    @(negedge clk);
    chk("cvt_disp", 32'(value_to_display), 32'hDE);
    repeat (2) @(negedge clk);
    chk("cvt_no_early", 32'(disp_idx), 32'd3);
    @(negedge clk);
    chk("cvt_step_idx", 32'(disp_idx), 32'd0);
    chk("cvt_step_disp", 32'(value_to_display), 32'hEF);
`endif

    // Asynchronous reset in the middle of operation
    repeat (5) @(negedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("arst_disp", 32'(value_to_display), 32'h0);
    chk("arst_led", 32'(value_to_LEDs), 32'h0);
    chk("arst_idx", 32'(disp_idx), 32'd3);
    chk("arst_valid", 32'(disp_valid), 32'd0);
    chk("arst_rdy", 32'(in_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Random traffic against the model
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      in_valid = 1'($urandom_range(0, 1));
      in_data  = $urandom();
      if ($urandom_range(0, 15) == 0) hold = ~hold;
      if ($urandom_range(0, 24) == 0) mode = ~mode;
      if ($urandom_range(0, 7) == 0) sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) led_sel = 2'($urandom_range(0, 3));
    end
    hold = 0; in_valid = 0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
